i2c_target_adc: RTL and testbench

I2C_TARGET_ADC -- requirements
Module: i2c_target_adc

---
 rtl/i2c_target_adc.sv | 178 +++++++++++++++++
 tb/tb_i2c_target_adc.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_adc.sv
// i2c_target_adc: I2C target returning a snapshotted 16-bit sample on read and capturing written bytes.
// Define I2C_TGT_GLITCH_FILTER_EN to add a 3-sample majority filter on SCL and SDA.
module i2c_target_adc #(
    parameter logic [6:0] ADDR = 7'h48,
    parameter logic [7:0] FILL = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    input  logic [15:0] sample,
    output logic [7:0]  wr_data,
    output logic        wr_valid,
    output logic        rd_done,
    output logic        busy
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_RD_BYTE, ST_RD_ACK, ST_WR_BYTE, ST_WR_ACK
    } state_t;

    state_t      state;
    logic [1:0]  scl_sync, sda_sync;
    logic        scl, sda, scl_q, sda_q;
    logic        scl_rise, scl_fall, start, stop;
    logic [3:0]  cnt;
    logic [7:0]  shift, tx, nxt;
    logic [1:0]  idx;
    logic        rw;
    logic [15:0] shadow;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
        end
    end

`ifdef I2C_TGT_GLITCH_FILTER_EN
    logic [2:0] scl_hist, sda_hist;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_hist <= 3'b111;
            sda_hist <= 3'b111;
        end else begin
            scl_hist <= {scl_hist[1:0], scl_sync[1]};
            sda_hist <= {sda_hist[1:0], sda_sync[1]};
        end
    end
    assign scl = (scl_hist[0] & scl_hist[1]) | (scl_hist[0] & scl_hist[2]) | (scl_hist[1] & scl_hist[2]);
    assign sda = (sda_hist[0] & sda_hist[1]) | (sda_hist[0] & sda_hist[2]) | (sda_hist[1] & sda_hist[2]);
`else
    assign scl = scl_sync[1];
    assign sda = sda_sync[1];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl;
            sda_q <= sda;
        end
    end

    assign scl_rise = scl & ~scl_q;
    assign scl_fall = ~scl & scl_q;
    assign start    = scl & scl_q & sda_q & ~sda;
    assign stop     = scl & scl_q & ~sda_q & sda;
    assign nxt      = (idx == 2'd0) ? shadow[15:8] : (idx == 2'd1) ? shadow[7:0] : FILL;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            shift    <= '0;
            tx       <= '0;
            idx      <= '0;
            rw       <= 1'b0;
            shadow   <= '0;
            sda_oe   <= 1'b0;
            wr_data  <= '0;
            wr_valid <= 1'b0;
            rd_done  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            wr_valid <= 1'b0;
            rd_done  <= 1'b0;
            if (start) begin
                state  <= ST_ADDR;
                cnt    <= '0;
                idx    <= '0;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (stop) begin
                state  <= ST_IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR: if (scl_rise) begin
                        shift <= {shift[6:0], sda};
                        cnt   <= cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            rw    <= sda;
                            cnt   <= '0;
                            busy  <= (shift[6:0] == ADDR);
                            state <= (shift[6:0] == ADDR) ? ST_ADDR_ACK : ST_IDLE;
                        end
                    end
                    // cnt==0: ACK not yet driven; otherwise the ACK low phase is ending
                    ST_ADDR_ACK: if (scl_fall) begin
                        if (cnt == 4'd0) begin
                            sda_oe <= 1'b1;
                            cnt    <= 4'd1;
                            if (rw) shadow <= sample;
                        end else if (rw) begin
                            sda_oe <= ~nxt[7];
                            tx     <= {nxt[6:0], 1'b0};
                            idx    <= (idx == 2'd2) ? idx : idx + 2'd1;
                            state  <= ST_RD_BYTE;
                        end else begin
                            sda_oe <= 1'b0;
                            cnt    <= '0;
                            state  <= ST_WR_BYTE;
                        end
                    end
                    ST_RD_BYTE: if (scl_fall) begin
                        if (cnt == 4'd8) begin
                            sda_oe <= 1'b0;
                            cnt    <= '0;
                            state  <= ST_RD_ACK;
                        end else begin
                            sda_oe <= ~tx[7];
                            tx     <= {tx[6:0], 1'b0};
                            cnt    <= cnt + 4'd1;
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise && sda) begin
                            rd_done <= 1'b1;
                            state   <= ST_IDLE;
                        end else if (scl_rise) begin
                            cnt <= 4'd1;
                        end else if (scl_fall && cnt == 4'd1) begin
                            sda_oe <= ~nxt[7];
                            tx     <= {nxt[6:0], 1'b0};
                            idx    <= (idx == 2'd2) ? idx : idx + 2'd1;
                            state  <= ST_RD_BYTE;
                        end
                    end
                    ST_WR_BYTE: if (scl_rise) begin
                        shift <= {shift[6:0], sda};
                        cnt   <= (cnt == 4'd7) ? 4'd0 : cnt + 4'd1;
                        if (cnt == 4'd7) state <= ST_WR_ACK;
                    end
                    ST_WR_ACK: if (scl_fall) begin
                        if (cnt == 4'd0) begin
                            sda_oe   <= 1'b1;
                            wr_data  <= shift;
                            wr_valid <= 1'b1;
                            cnt      <= 4'd1;
                        end else begin
                            sda_oe <= 1'b0;
                            cnt    <= '0;
                            state  <= ST_WR_BYTE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_target_adc.sv
// tb_i2c_target_adc: bit-banged I2C master with frame, write-data and rd_done scoreboards.
module tb_i2c_target_adc;
    localparam int H = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl = 1'b1;
    logic        sda_m = 1'b1;
    logic [15:0] sample = 16'hA55A;
    logic        sda_oe, wr_valid, rd_done, busy, sda_line;
    logic [7:0]  wr_data;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_frames[$];
    logic [7:0] exp_wr[$];
    int rd_pending = 0;
    logic busy_forbid = 1'b0;
    int busy_bad = 0;

    assign sda_line = sda_m & ~sda_oe;

    i2c_target_adc dut (
        .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda_line), .sda_oe(sda_oe),
        .sample(sample), .wr_data(wr_data), .wr_valid(wr_valid), .rd_done(rd_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: frames on the bus, write pulses and read-done pulses against the queues
    logic       scl_p = 1'b1, sda_p = 1'b1;
    logic [8:0] frame = '0;
    int         nbits = 0;
    always @(negedge clk) begin
        if (wr_valid) begin
            if (exp_wr.size() == 0) begin
                checks++; errors++;
                $display("FAIL wr_valid: unexpected pulse with wr_data %h", wr_data);
            end else check("wr_data", 32'(wr_data), 32'(exp_wr.pop_front()));
        end
        if (rd_done) begin
            checks++;
            if (rd_pending == 0) begin
                errors++;
                $display("FAIL rd_done: unexpected pulse, none pending");
            end else rd_pending--;
        end
        if (busy_forbid && busy) busy_bad++;
        if (scl_p && scl && sda_p != sda_line) nbits = 0;
        else if (!scl_p && scl) begin
            frame = {frame[7:0], sda_line};
            nbits++;
            if (nbits == 9) begin
                nbits = 0;
                if (exp_frames.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL frame: unexpected frame %h", frame);
                end else check("frame byte+ack", 32'(frame), 32'(exp_frames.pop_front()));
            end
        end
        scl_p = scl;
        sda_p = sda_line;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        tick(H / 2); sda_m = 1'b1; tick(H); scl = 1'b1; tick(H); sda_m = 1'b0; tick(H); scl = 1'b0;
    endtask

    task automatic i2c_stop();
        tick(H / 2); sda_m = 1'b0; tick(H / 2); scl = 1'b1; tick(H); sda_m = 1'b1; tick(H);
    endtask

    task automatic send_bit(input logic b);
        tick(H / 2); sda_m = b; tick(H / 2); scl = 1'b1; tick(H); scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, input logic ack);
        exp_frames.push_back({b, ack});
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        send_bit(1'b1);
    endtask

    task automatic read_byte(input logic [7:0] b, input logic ack);
        exp_frames.push_back({b, ack});
        repeat (8) send_bit(1'b1);
        send_bit(ack);
    endtask

    initial begin
        #2 rst = 1'b0;
        tick(3);
        check("reset sda_oe", 32'(sda_oe), 0);
        check("reset wr_data", 32'(wr_data), 0);
        check("reset wr_valid", 32'(wr_valid), 0);
        check("reset rd_done", 32'(rd_done), 0);
        check("reset busy", 32'(busy), 0);
        rst = 1'b1;
        tick(5);
        // two-byte read of the sample, NACK on the last byte
        i2c_start();
        write_byte(8'h91, 1'b0);
        check("busy after match", 32'(busy), 1);
        read_byte(8'hA5, 1'b0);
        rd_pending++;
        read_byte(8'h5A, 1'b1);
        i2c_stop();
        tick(4);
        check("busy after stop", 32'(busy), 0);
        // wrong address: no ACK, never busy
        busy_forbid = 1'b1;
        i2c_start();
        write_byte(8'h92, 1'b1);
        i2c_stop();
        busy_forbid = 1'b0;
        check("busy on mismatch", 32'(busy_bad), 0);
        // two-byte write
        exp_wr.push_back(8'h12);
        exp_wr.push_back(8'h34);
        i2c_start();
        write_byte(8'h90, 1'b0);
        write_byte(8'h12, 1'b0);
        write_byte(8'h34, 1'b0);
        i2c_stop();
        // snapshot held while sample changes, third byte is FILL
        sample = 16'hA55A;
        i2c_start();
        write_byte(8'h91, 1'b0);
        sample = 16'h1111;
        read_byte(8'hA5, 1'b0);
        read_byte(8'h5A, 1'b0);
        rd_pending++;
        read_byte(8'hFF, 1'b1);
        i2c_stop();
        // repeated start mid-write, then read of the current sample
        sample = 16'hBEEF;
        i2c_start();
        write_byte(8'h90, 1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        i2c_start();
        write_byte(8'h91, 1'b0);
        read_byte(8'hBE, 1'b0);
        rd_pending++;
        read_byte(8'hEF, 1'b1);
        i2c_stop();
        // reset while driving a 0 bit, then a normal transfer
        sample = 16'hA55A;
        i2c_start();
        write_byte(8'h91, 1'b0);
        send_bit(1'b1);
        tick(6);
        check("driving bit6 low", 32'(sda_oe), 1);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("sda_oe on async reset", 32'(sda_oe), 0);
        check("busy on async reset", 32'(busy), 0);
        tick(3);
        rst = 1'b1;
        tick(3);
        i2c_start();
        write_byte(8'h91, 1'b0);
        read_byte(8'hA5, 1'b0);
        rd_pending++;
        read_byte(8'h5A, 1'b1);
        i2c_stop();
        tick(20);
        check("frames outstanding", 32'(exp_frames.size()), 0);
        check("writes outstanding", 32'(exp_wr.size()), 0);
        check("rd_done outstanding", 32'(rd_pending), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
